// File: rtl/cam_bringup_seq.sv
// Camera power-up / configuration sequencer.
// Walks the sensor through power-down release, XCLK start, a reset pulse and
// a boot settle time. It then launches the SCCB config engine and watches it
// with a timeout.
//
// Optional feature: define CAM_BRINGUP_RETRY_EN to enable up to three automatic
// full re-sequences after a config failure. This also adds the retry_cnt output.
//
// Pin map per state, as {xclk_en, cam_pwdn, cam_resetn}:
//   IDLE/PWDN/ERROR: 0,1,0
//   XCLK: 1,0,1
//   RST: 1,0,0
//   BOOT/CFG/READY: 1,0,1
// All outputs are flops loaded from the next-state decode, so they line up with state_o.
module cam_bringup_seq #(
  parameter int unsigned T_PWDN_CYC   = 125000,
  parameter int unsigned T_XCLK_CYC   = 12500,
  parameter int unsigned T_RST_CYC    = 125000,
  parameter int unsigned T_BOOT_CYC   = 625000,
  parameter int unsigned T_CFG_TO_CYC = 12500000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       clk_125mhz,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       cfg_done,
  input  logic       cfg_err,
  output logic       xclk_en,
  output logic       cam_pwdn,
  output logic       cam_resetn,
  output logic       cfg_start,
  output logic       ready,
  output logic       error,
`ifdef CAM_BRINGUP_RETRY_EN
  output logic [1:0] retry_cnt,
`endif
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPwdn  = 3'd1,
    StXclk  = 3'd2,
    StRst   = 3'd3,
    StBoot  = 3'd4,
    StCfg   = 3'd5,
    StReady = 3'd6,
    StError = 3'd7
  } state_e;

  // Last counter value of a state lasting n cycles (n = 0 behaves as 1).
  function automatic logic [CNT_W-1:0] last_cycle(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

  localparam logic [CNT_W-1:0] PwdnLast = last_cycle(T_PWDN_CYC);
  localparam logic [CNT_W-1:0] XclkLast = last_cycle(T_XCLK_CYC);
  localparam logic [CNT_W-1:0] RstLast  = last_cycle(T_RST_CYC);
  localparam logic [CNT_W-1:0] BootLast = last_cycle(T_BOOT_CYC);
  localparam logic [CNT_W-1:0] CfgLast  = last_cycle(T_CFG_TO_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xclk_en_q, xclk_en_d;
  logic             pwdn_q, pwdn_d;
  logic             resetn_q, resetn_d;
  logic             cfg_start_q, cfg_start_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
`ifdef CAM_BRINGUP_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  // Next-state, wait counter and retry bookkeeping.
  always_comb begin
    state_d = state_q;
`ifdef CAM_BRINGUP_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      StIdle:  if (start) state_d = StPwdn;
      StPwdn:  if (cnt_q == PwdnLast) state_d = StXclk;
      StXclk:  if (cnt_q == XclkLast) state_d = StRst;
      StRst:   if (cnt_q == RstLast) state_d = StBoot;
      StBoot:  if (cnt_q == BootLast) state_d = StCfg;
      StCfg: begin
        // cfg_err beats cfg_done; cfg_done beats a timeout landing on the same cycle.
        if (cfg_err || (!cfg_done && cnt_q == CfgLast)) begin
`ifdef CAM_BRINGUP_RETRY_EN
          if (retry_q != 2'd3) begin
            state_d = StPwdn;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d = StError;
          end
`else
          state_d = StError;
`endif
        end else if (cfg_done) begin
          state_d = StReady;
        end
      end
      StReady: state_d = StReady;
      StError: if (start) state_d = StPwdn;
      default: state_d = StIdle;
    endcase
    if (stop) begin
      state_d = StIdle;
`ifdef CAM_BRINGUP_RETRY_EN
      retry_d = 2'd0;
`endif
    end
`ifdef CAM_BRINGUP_RETRY_EN
    if (state_d == StReady && state_q != StReady) retry_d = 2'd0;
`endif
    // Untimed states keep the counter parked at zero.
    if (state_d != state_q || state_q inside {StIdle, StReady, StError}) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pin decode of the next state, so the registered pins track state_o.
  always_comb begin
    xclk_en_d   = 1'b0;
    pwdn_d      = 1'b1;
    resetn_d    = 1'b0;
    unique case (state_d)
      StXclk, StBoot, StCfg, StReady: begin
        xclk_en_d = 1'b1;
        pwdn_d    = 1'b0;
        resetn_d  = 1'b1;
      end
      StRst: begin
        xclk_en_d = 1'b1;
        pwdn_d    = 1'b0;
      end
      default: ;
    endcase
    cfg_start_d = (state_d == StCfg) && (state_q != StCfg);
    ready_d     = (state_d == StReady);
    error_d     = (state_d == StError);
  end

  // State, counter and output registers; reset parks the sensor powered down.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      xclk_en_q   <= 1'b0;
      pwdn_q      <= 1'b1;
      resetn_q    <= 1'b0;
      cfg_start_q <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
`ifdef CAM_BRINGUP_RETRY_EN
      retry_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xclk_en_q   <= xclk_en_d;
      pwdn_q      <= pwdn_d;
      resetn_q    <= resetn_d;
      cfg_start_q <= cfg_start_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
`ifdef CAM_BRINGUP_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign xclk_en    = xclk_en_q;
  assign cam_pwdn   = pwdn_q;
  assign cam_resetn = resetn_q;
  assign cfg_start  = cfg_start_q;
  assign ready      = ready_q;
  assign error      = error_q;
  assign state_o    = state_q;
`ifdef CAM_BRINGUP_RETRY_EN
  assign retry_cnt  = retry_q;
`endif

endmodule
